// File: rtl/fp_int_pkg.sv
// Shared FP16 field constants, canonical encodings and the converter FSM state type.
package fp_int_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;
  localparam logic [EXP_W-1:0] EXP_INF = 5'h1F;

  localparam logic [15:0] POS_ZERO = 16'h0000;
  localparam logic [15:0] POS_INF  = 16'h7C00;

  // Wide enough for (ACC_WIDTH-1-lz) + exp_in - FRAC_BITS plus a rounding carry.
  localparam int E_CALC_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_NORM  = 2'd2,
    ST_ROUND = 2'd3
  } conv_state_t;

endpackage

// File: rtl/acc_to_fp16_if.sv
// Request/result bundle between the MAC side and the accumulator-to-FP16 converter.
interface acc_to_fp16_if #(
  parameter int ACC_WIDTH = 32
);
  import fp_int_pkg::*;

  // Handshake: start is a request taken only while busy=0; there is no backpressure.
  // done is a one-cycle pulse qualifying fp16_out/overflow/underflow, which hold until the next done.
  logic                 start;
  logic [ACC_WIDTH-1:0] fixed_point_in;
  logic [4:0]           exp_in;
  logic [15:0]          fp16_out;
  logic                 done;
  logic                 busy;
  logic                 overflow;
  logic                 underflow;
  conv_state_t          dbg_state;

  modport master (
    output start, fixed_point_in, exp_in,
    input  fp16_out, done, busy, overflow, underflow, dbg_state
  );

  modport slave (
    input  start, fixed_point_in, exp_in,
    output fp16_out, done, busy, overflow, underflow, dbg_state
  );

endinterface

// File: rtl/fp16_rne_round.sv
// Combinational round-to-nearest-even of a normalised magnitude into FP16,
// saturating to signed infinity on overflow and flushing to signed zero on underflow.
module fp16_rne_round
  import fp_int_pkg::*;
#(
  parameter int ACC_WIDTH = 32
) (
  input  logic                       i_sign,
  input  logic signed [E_CALC_W-1:0] i_exp,
  input  logic [ACC_WIDTH-2:0]       i_frac,
  output logic [15:0]                o_fp16,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam logic signed [E_CALC_W-1:0] E_MAX = E_CALC_W'(31);
  localparam logic signed [E_CALC_W-1:0] E_MIN = E_CALC_W'(0);

  logic [MAN_W-1:0]          w_man;
  logic                      w_guard;
  logic                      w_sticky;
  logic                      w_inc;
  logic [MAN_W:0]            w_man_rnd;
  logic signed [E_CALC_W-1:0] w_exp_rnd;

  // i_frac excludes the implicit leading one, so the mantissa is its top MAN_W bits.
  assign w_man     = i_frac[ACC_WIDTH-2 -: MAN_W];
  assign w_guard   = i_frac[ACC_WIDTH-2-MAN_W];
  assign w_sticky  = |(i_frac << (MAN_W + 1));
  assign w_inc     = w_guard & (w_sticky | w_man[0]);
  assign w_man_rnd = {1'b0, w_man} + (MAN_W+1)'(w_inc);
  assign w_exp_rnd = i_exp + E_CALC_W'(w_man_rnd[MAN_W]);

  always_comb begin
    o_fp16      = POS_ZERO;
    o_overflow  = 1'b0;
    o_underflow = 1'b0;
    if (w_exp_rnd >= E_MAX) begin
      o_fp16     = {i_sign, EXP_INF, {MAN_W{1'b0}}};
      o_overflow = 1'b1;
    end else if (w_exp_rnd <= E_MIN) begin
      o_fp16      = {i_sign, 15'h0000};
      o_underflow = 1'b1;
    end else begin
      o_fp16 = {i_sign, w_exp_rnd[EXP_W-1:0], w_man_rnd[MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/acc_to_fp16.sv
// Multi-cycle converter from a signed fixed-point accumulator plus shared block
// exponent to an FP16 activation: magnitude, 1-bit/cycle normalise, RNE round.
module acc_to_fp16
  import fp_int_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int FRAC_BITS = 10
) (
  input  logic          clk,
  input  logic          rst,
  acc_to_fp16_if.slave  bus
);

  localparam int LZ_W = $clog2(ACC_WIDTH) + 1;

  conv_state_t           r_state;
  logic [ACC_WIDTH-1:0]  r_mag;
  logic                  r_sign;
  logic [4:0]            r_exp;
  logic [LZ_W-1:0]       r_lz;
  logic [15:0]           r_fp16;
  logic                  r_done;
  logic                  r_ovf;
  logic                  r_unf;

  logic signed [E_CALC_W-1:0] w_exp;
  logic [15:0]                w_fp16;
  logic                       w_ovf;
  logic                       w_unf;

  assign w_exp = E_CALC_W'(ACC_WIDTH - 1) - E_CALC_W'(r_lz)
               + E_CALC_W'(r_exp) - E_CALC_W'(FRAC_BITS);

  fp16_rne_round #(.ACC_WIDTH(ACC_WIDTH)) u_round (
    .i_sign      (r_sign),
    .i_exp       (w_exp),
    .i_frac      (r_mag[ACC_WIDTH-2:0]),
    .o_fp16      (w_fp16),
    .o_overflow  (w_ovf),
    .o_underflow (w_unf)
  );

  // Results are registered on the edge that enters ROUND, so done is high
  // exactly while the FSM sits in ROUND.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mag   <= '0;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_lz    <= '0;
      r_fp16  <= POS_ZERO;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mag   <= bus.fixed_point_in;
            r_exp   <= bus.exp_in;
            r_lz    <= '0;
            r_state <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_sign <= r_mag[ACC_WIDTH-1];
          // Negating the most negative value wraps to 2^(ACC_WIDTH-1), the correct unsigned magnitude.
          r_mag  <= r_mag[ACC_WIDTH-1] ? -r_mag : r_mag;
          if (r_mag == '0) begin
            r_fp16  <= POS_ZERO;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_ROUND;
          end else begin
            r_state <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (r_mag[ACC_WIDTH-1]) begin
            r_fp16  <= w_fp16;
            r_ovf   <= w_ovf;
            r_unf   <= w_unf;
            r_done  <= 1'b1;
            r_state <= ST_ROUND;
          end else begin
            r_mag <= r_mag << 1;
            r_lz  <= r_lz + LZ_W'(1);
          end
        end
        ST_ROUND: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.fp16_out  = r_fp16;
  assign bus.done      = r_done;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_acc_to_fp16.sv
// Self-checking bench for acc_to_fp16: table of conversions with expected FP16,
// flags and latency, plus sequences for ignored starts and mid-conversion reset.
module tb_acc_to_fp16;
  import fp_int_pkg::*;

  localparam int AW = 32;
  localparam int W  = 18;
  localparam int NV = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acc_to_fp16_if #(.ACC_WIDTH(AW)) bus ();

  acc_to_fp16 #(.ACC_WIDTH(AW), .FRAC_BITS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [AW-1:0] acc;
    logic [4:0]    ex;
    logic [15:0]   fp;
    logic          ovf;
    logic          unf;
    int            lat;
  } vec_t;

  vec_t          vecs[NV];
  logic [W-1:0]  exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Waits up to 100 edges for done; edges counts the start-sampling edge as 1.
  task automatic wait_done(input int start_edges, output int edges, output bit seen);
    edges = start_edges;
    seen  = (bus.done === 1'b1);
    while (!seen && edges < 100) begin
      @(posedge clk);
      edges++;
      #1 seen = (bus.done === 1'b1);
    end
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(posedge clk);
      #1 if (bus.done === 1'b1) cnt++;
    end
  endtask

  task automatic drive_start(input logic [AW-1:0] acc, input logic [4:0] ex);
    @(negedge clk);
    bus.start          = 1'b1;
    bus.fixed_point_in = acc;
    bus.exp_in         = ex;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int           edges;
    bit           seen;
    logic [W-1:0] e;
    exp_q.push_back({v.fp, v.ovf, v.unf});
    drive_start(v.acc, v.ex);
    check($sformatf("v%0d_busy", idx), bus.busy, 1);
    wait_done(1, edges, seen);
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL v%0d_timeout: got no done expected done at edge %0d", idx, v.lat);
      exp_q.delete();
      return;
    end
    e = exp_q.pop_front();
    check($sformatf("v%0d_fp16", idx), bus.fp16_out, e[17:2]);
    check($sformatf("v%0d_ovf", idx), bus.overflow, e[1]);
    check($sformatf("v%0d_unf", idx), bus.underflow, e[0]);
    check($sformatf("v%0d_latency", idx), edges, v.lat);
    @(posedge clk);
    #1;
    check($sformatf("v%0d_done_pulse", idx), bus.done, 0);
    check($sformatf("v%0d_hold_fp16", idx), bus.fp16_out, e[17:2]);
    check($sformatf("v%0d_hold_ovf", idx), bus.overflow, e[1]);
    check($sformatf("v%0d_idle", idx), bus.busy, 0);
  endtask

  initial begin
    int  edges;
    int  cnt;
    bit  seen;

    vecs[0]  = '{32'h0000_0002, 5'd16, 16'h1C00, 1'b0, 1'b0, 33};
    vecs[1]  = '{32'h0000_0400, 5'd15, 16'h3C00, 1'b0, 1'b0, 24};
    vecs[2]  = '{32'hFFFF_F400, 5'd15, 16'hC200, 1'b0, 1'b0, 23};
    vecs[3]  = '{32'h0000_0801, 5'd15, 16'h4000, 1'b0, 1'b0, 23};
    vecs[4]  = '{32'h0000_0803, 5'd15, 16'h4002, 1'b0, 1'b0, 23};
    vecs[5]  = '{32'h0000_0FFF, 5'd15, 16'h4400, 1'b0, 1'b0, 23};
    vecs[6]  = '{32'h0000_1003, 5'd15, 16'h4401, 1'b0, 1'b0, 22};
    vecs[7]  = '{32'h7FFF_FFFF, 5'd31, 16'h7C00, 1'b1, 1'b0, 4};
    vecs[8]  = '{32'h0000_0001, 5'd0,  16'h0000, 1'b0, 1'b1, 34};
    vecs[9]  = '{32'h0000_0000, 5'd7,  16'h0000, 1'b0, 1'b0, 2};
    vecs[10] = '{32'h8000_0000, 5'd15, 16'hFC00, 1'b1, 1'b0, 3};
    vecs[11] = '{32'hFFFF_FFFF, 5'd0,  16'h8000, 1'b0, 1'b1, 34};
    vecs[12] = '{32'hFFFF_FFFF, 5'd25, 16'hBC00, 1'b0, 1'b0, 34};
    vecs[13] = '{32'h4000_0000, 5'd0,  16'h5000, 1'b0, 1'b0, 4};
    vecs[14] = '{32'h0000_0400, 5'd30, 16'h7800, 1'b0, 1'b0, 24};
    vecs[15] = '{32'h0000_0400, 5'd31, 16'h7C00, 1'b1, 1'b0, 24};
    vecs[16] = '{32'h0000_0FFF, 5'd29, 16'h7C00, 1'b1, 1'b0, 23};
    vecs[17] = '{32'h0000_0400, 5'd1,  16'h0400, 1'b0, 1'b0, 24};
    vecs[18] = '{32'h0000_0400, 5'd0,  16'h0000, 1'b0, 1'b1, 24};
    vecs[19] = '{32'h0000_0000, 5'd31, 16'h0000, 1'b0, 1'b0, 2};

    // Clock/reset
    bus.start          = 1'b0;
    bus.fixed_point_in = '0;
    bus.exp_in         = '0;
    rst                = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_fp16", bus.fp16_out, 16'h0000);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_unf", bus.underflow, 0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;

    // Table-driven conversions with random idle gaps
    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], i);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // Second start during NORM is ignored; exactly one done with the first result
    drive_start(32'h0000_0002, 5'd16);
    repeat (4) @(posedge clk);
    drive_start(32'h0000_0400, 5'd15);
    wait_done(6, edges, seen);
    check("norm_start_seen", 32'(seen), 1);
    check("norm_start_fp16", bus.fp16_out, 16'h1C00);
    check("norm_start_latency", edges, 33);
    count_dones(40, cnt);
    check("norm_start_extra_done", cnt, 0);

    // Start coinciding with done (FSM in ROUND) is ignored
    drive_start(32'h0000_0400, 5'd15);
    wait_done(1, edges, seen);
    check("round_start_seen", 32'(seen), 1);
    check("round_start_fp16", bus.fp16_out, 16'h3C00);
    bus.start          = 1'b1;
    bus.fixed_point_in = 32'h0000_0002;
    bus.exp_in         = 5'd16;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("round_start_busy", bus.busy, 0);
    count_dones(40, cnt);
    check("round_start_extra_done", cnt, 0);

    // Overflow result from the previous vector table is replaced; now reset mid-NORM
    drive_start(32'h8000_0000, 5'd15);
    wait_done(1, edges, seen);
    check("pre_rst_ovf", bus.overflow, 1);
    drive_start(32'h0000_0001, 5'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_fp16", bus.fp16_out, 16'h0000);
    check("midrst_done", bus.done, 0);
    check("midrst_ovf", bus.overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    count_dones(40, cnt);
    check("midrst_no_done", cnt, 0);
    run_vec(vecs[2], 100);

    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
